fp_stft_framer: RTL and testbench



---
 rtl/fp_stft_framer.sv | 127 ++++++++++++
 tb/tb_fp_stft_framer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_stft_framer.sv
// Frame sequencer ahead of the FP32 STFT datapath: keeps the last W samples in a
// circular store and, once per HOP new samples, emits a W-sample frame paired with window coefficients.
module fp_stft_framer #(
   parameter int W   = 4,
   parameter int HOP = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [$clog2(W)-1:0] win_index,
   input  logic [31:0]          win_re,
   input  logic [31:0]          win_im,
   input  logic                 win_valid,
   output logic [31:0]          out_data,
   output logic [31:0]          out_re_w,
   output logic [31:0]          out_im_w,
   output logic [$clog2(W)-1:0] out_index,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int AW = $clog2(W);
   localparam int NW = AW + 1;

   typedef enum logic [1:0] {FILL, EMIT, DRAIN} state_t;

   state_t          state, state_nx;
   logic            run;
   logic [AW-1:0]   wr_ptr, base, k, rd_addr;
   logic [NW-1:0]   need;
   logic [31:0]     mem [W];
   logic            accept, load, drain_done;

   assign rd_addr = base + k;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_nx   = state;
      accept     = 1'b0;
      load       = 1'b0;
      drain_done = 1'b0;
      in_ready   = 1'b0;
      win_index  = '0;
      unique case (state)
         FILL: begin
            // run keeps in_ready low during reset and for the first cycle after it.
            in_ready = run;
            accept   = in_valid & run;
            if (accept && need == NW'(1)) state_nx = EMIT;
         end
         EMIT: begin
            win_index = k;
            load      = win_valid & (!out_valid | out_ready);
            if (load && k == AW'(W - 1)) state_nx = DRAIN;
         end
         DRAIN: begin
            drain_done = out_valid & out_ready;
            if (drain_done) state_nx = FILL;
         end
         default: state_nx = FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run    <= 1'b0;
         wr_ptr <= '0;
         need   <= NW'(W);
         base   <= '0;
         k      <= '0;
      end else begin
         run <= 1'b1;
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            need   <= need - 1'b1;
            // The slot after the newest sample holds the oldest one of the frame.
            if (need == NW'(1)) begin
               base <= wr_ptr + 1'b1;
               k    <= '0;
            end
         end
         if (load)       k    <= k + 1'b1;
         if (drain_done) need <= NW'(HOP);
      end
   end

   // NOTE: the sample store is deliberately not reset; wr_ptr/need already make
   // stale contents unreachable, and a reset-free array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_re_w  <= '0;
         out_im_w  <= '0;
         out_index <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= mem[rd_addr];
         out_re_w  <= win_re;
         out_im_w  <= win_im;
         out_index <= k;
         out_first <= (k == '0);
         out_last  <= (k == AW'(W - 1));
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_stft_framer.sv
// Directed bench for fp_stft_framer: one instance with HOP=W, one with HOP=2 for
// the overlap case; a mux selects which instance the shared tasks observe.
module tb_fp_stft_framer;

   localparam int W  = 4;
   localparam int AW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   in_data;
   logic          in_valid;
   logic          win_valid;
   logic          out_ready;
   logic [31:0]   win_re, win_im;
   logic          sel;

   logic          in_ready_a, out_first_a, out_last_a, out_valid_a;
   logic          in_ready_b, out_first_b, out_last_b, out_valid_b;
   logic [AW-1:0] win_index_a, out_index_a, win_index_b, out_index_b;
   logic [31:0]   out_data_a, out_re_w_a, out_im_w_a;
   logic [31:0]   out_data_b, out_re_w_b, out_im_w_b;

   logic          o_in_ready, o_first, o_last, o_valid;
   logic [AW-1:0] o_win_index, o_index;
   logic [31:0]   o_data, o_re, o_im;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int beat_cyc;

   always #5 clk = ~clk;

   fp_stft_framer #(.W(W), .HOP(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid & !sel),
      .in_ready(in_ready_a), .win_index(win_index_a), .win_re(win_re), .win_im(win_im),
      .win_valid(win_valid), .out_data(out_data_a), .out_re_w(out_re_w_a),
      .out_im_w(out_im_w_a), .out_index(out_index_a), .out_first(out_first_a),
      .out_last(out_last_a), .out_valid(out_valid_a), .out_ready(out_ready)
   );

   fp_stft_framer #(.W(W), .HOP(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid & sel),
      .in_ready(in_ready_b), .win_index(win_index_b), .win_re(win_re), .win_im(win_im),
      .win_valid(win_valid), .out_data(out_data_b), .out_re_w(out_re_w_b),
      .out_im_w(out_im_w_b), .out_index(out_index_b), .out_first(out_first_b),
      .out_last(out_last_b), .out_valid(out_valid_b), .out_ready(out_ready)
   );

   always_comb begin
      o_in_ready  = sel ? in_ready_b  : in_ready_a;
      o_win_index = sel ? win_index_b : win_index_a;
      o_data      = sel ? out_data_b  : out_data_a;
      o_re        = sel ? out_re_w_b  : out_re_w_a;
      o_im        = sel ? out_im_w_b  : out_im_w_a;
      o_index     = sel ? out_index_b : out_index_a;
      o_first     = sel ? out_first_b : out_first_a;
      o_last      = sel ? out_last_b  : out_last_a;
      o_valid     = sel ? out_valid_b : out_valid_a;
   end

   // Coefficient ROM stand-in: distinct value per index so mispairing shows up.
   function automatic logic [31:0] coef_re(input int idx);
      return 32'h3F80_0000 + 32'(idx);
   endfunction

   function automatic logic [31:0] coef_im(input int idx);
      return 32'h3E00_0000 + 32'(idx * 16);
   endfunction

   always_comb begin
      win_re = coef_re(int'(o_win_index));
      win_im = coef_im(int'(o_win_index));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic feed(input logic [31:0] data);
      bit done = 0;
      in_valid = 1'b1;
      in_data  = data;
      for (int i = 0; i < 20 && !done; i++) begin
         if (o_in_ready) done = 1;
         tick();
      end
      in_valid = 1'b0;
      if (!done) check("feed_timeout", 32'd0, 32'd1);
   endtask

   task automatic get_beat(input logic [31:0] exp_data, input int exp_idx);
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (o_valid && out_ready) begin
            check("beat_data",  o_data, exp_data);
            check("beat_index", 32'(o_index), 32'(exp_idx));
            check("beat_first", 32'(o_first), 32'(exp_idx == 0));
            check("beat_last",  32'(o_last),  32'(exp_idx == W - 1));
            check("beat_re",    o_re, coef_re(exp_idx));
            check("beat_im",    o_im, coef_im(exp_idx));
            check("beat_in_ready_low", 32'(o_in_ready), 32'd0);
            beat_cyc = cyc;
            done = 1;
         end
         tick();
      end
      if (!done) check("beat_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int prev;
      int accepts;
      logic [31:0] held_data, held_re, held_im;
      logic [31:0] frame_a [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; win_valid = 1'b1;
      out_ready = 1'b1; sel = 1'b0;
      tick(); tick();

      // reset state
      check("rst_out_valid", 32'(o_valid), 32'd0);
      check("rst_out_data",  o_data, 32'd0);
      check("rst_out_re",    o_re, 32'd0);
      check("rst_out_index", 32'(o_index), 32'd0);
      check("rst_first_last", {30'd0, o_first, o_last}, 32'd0);
      check("rst_win_index", 32'(o_win_index), 32'd0);
      check("rst_in_ready",  32'(o_in_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(o_in_ready), 32'd1);

      // basic frame, HOP=W
      for (int i = 0; i < 4; i++) feed(frame_a[i]);
      check("t1_in_ready_after_fill", 32'(o_in_ready), 32'd0);
      check("t1_latency_no_beat",     32'(o_valid), 32'd0);
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         get_beat(frame_a[i], i);
         if (i > 0) check("t1_back_to_back", 32'(beat_cyc - prev), 32'd1);
         prev = beat_cyc;
      end
      check("t1_in_ready_after_last", 32'(o_in_ready), 32'd1);
      check("t1_out_valid_cleared",   32'(o_valid), 32'd0);

      // overlap, HOP=2
      sel = 1'b1;
      for (int i = 0; i < 4; i++) feed(frame_a[i]);
      for (int i = 0; i < 4; i++) get_beat(frame_a[i], i);
      feed(32'h40A0_0000);
      check("t2_still_filling", 32'(o_in_ready), 32'd1);
      feed(32'h40C0_0000);
      check("t2_emit_after_two", 32'(o_in_ready), 32'd0);
      get_beat(32'h4040_0000, 0);
      get_beat(32'h4080_0000, 1);
      get_beat(32'h40A0_0000, 2);
      get_beat(32'h40C0_0000, 3);
      sel = 1'b0;

      // output backpressure at index 2
      feed(32'h40E0_0000); feed(32'h4100_0000); feed(32'h4110_0000); feed(32'h4120_0000);
      get_beat(32'h40E0_0000, 0);
      get_beat(32'h4100_0000, 1);
      out_ready = 1'b0;
      held_data = o_data; held_re = o_re; held_im = o_im;
      check("t3_presented_index", 32'(o_index), 32'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_hold_valid", 32'(o_valid), 32'd1);
         check("t3_hold_data",  o_data, 32'h4110_0000);
         check("t3_hold_index", 32'(o_index), 32'd2);
         check("t3_hold_re",    o_re, held_re);
         check("t3_hold_im",    o_im, held_im);
      end
      out_ready = 1'b1;
      get_beat(32'h4110_0000, 2);
      check("t3_next_index_now", 32'(o_index), 32'd3);
      check("t3_next_valid_now", 32'(o_valid), 32'd1);
      get_beat(32'h4120_0000, 3);

      // coefficient stall at k=1
      feed(32'h4130_0000); feed(32'h4140_0000); feed(32'h4150_0000); feed(32'h4160_0000);
      tick();
      check("t4_beat0_index", 32'(o_index), 32'd0);
      check("t4_beat0_data",  o_data, 32'h4130_0000);
      win_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t4_stall_win_index", 32'(o_win_index), 32'd1);
         check("t4_stall_no_beat",   32'(o_valid), 32'd0);
      end
      win_valid = 1'b1;
      get_beat(32'h4140_0000, 1);
      get_beat(32'h4150_0000, 2);
      get_beat(32'h4160_0000, 3);

      // reset in the middle of a frame
      feed(32'h4170_0000); feed(32'h4180_0000); feed(32'h4188_0000); feed(32'h4190_0000);
      tick(); tick();
      check("t5_pre_rst_win_index", 32'(o_win_index), 32'd2);
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", 32'(o_valid), 32'd0);
      check("t5_rst_in_ready",  32'(o_in_ready), 32'd0);
      check("t5_rst_out_data",  o_data, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("t5_release_in_ready_low", 32'(o_in_ready), 32'd0);
      tick();
      check("t5_release_in_ready", 32'(o_in_ready), 32'd1);
      feed(32'h4198_0000); feed(32'h41A0_0000); feed(32'h41A8_0000);
      check("t5_three_not_enough", 32'(o_in_ready), 32'd1);
      feed(32'h41B0_0000);
      get_beat(32'h4198_0000, 0);
      get_beat(32'h41A0_0000, 1);
      get_beat(32'h41A8_0000, 2);
      get_beat(32'h41B0_0000, 3);

      // gapped input during FILL: pattern 1,0,0,1,1,0,1
      accepts = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = (i == 0 || i == 3 || i == 4 || i == 6);
         in_data  = 32'h4200_0000 + 32'(i);
         if (in_valid && o_in_ready) accepts++;
         tick();
      end
      in_valid = 1'b0;
      check("t6_accept_count",   32'(accepts), 32'd4);
      check("t6_in_ready_emit",  32'(o_in_ready), 32'd0);
      get_beat(32'h4200_0000, 0);
      get_beat(32'h4200_0003, 1);
      get_beat(32'h4200_0004, 2);
      get_beat(32'h4200_0006, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
